// File: rtl/echo_pkg.sv
// Shared constants for the echo frame writer: FSM encoding, header tag and sample packing.
package echo_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEADER  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  localparam logic [7:0] DEFAULT_HEADER_TAG = 8'hA5;
  localparam int         SAMPLE_SHIFT       = 1;

  // Dropping the ADC LSB frees bit 15, which stays 0 so headers are unambiguous.
  function automatic logic [15:0] sample_word(input logic [15:0] data);
    return 16'(data >> SAMPLE_SHIFT);
  endfunction

endpackage

// File: rtl/echo_frame_writer_sync_edge_det.sv
// Optional N-stage synchroniser followed by a rising-edge detector.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK_65,
  input  logic RST,
  input  logic D,
  output logic EDGE
);

  logic synced;
  logic prev;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign synced = D;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge CLK_65) begin
        if (RST) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= D;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_65) begin
    if (RST) prev <= 1'b0;
    else     prev <= synced;
  end

  assign EDGE = synced & ~prev;

endmodule

// File: rtl/echo_frame_writer.sv
// Burst-aligned framer: writes {tag, id} then SAMPLES_PER_FRAME sample words into the FIFO.
module echo_frame_writer
  import echo_pkg::*;
#(
  parameter int unsigned SAMPLES_PER_FRAME = 512,
  parameter logic [7:0]  HEADER_TAG        = DEFAULT_HEADER_TAG
) (
  input  logic        CLK_65,
  input  logic        RST,
  input  logic        ON,
  input  logic        BURST,
  input  logic        SAMPLE_FIN,
  input  logic [15:0] SAMPLE_DATA,
  input  logic        FIFO_FULL,
  output logic        FIFO_WR,
  output logic [15:0] FIFO_DATA,
  output logic        FRAME_ACTIVE,
  output logic        OVERFLOW,
  output logic [7:0]  FRAME_ID
);

  localparam logic [15:0] LAST_INDEX = 16'(SAMPLES_PER_FRAME - 1);

  logic [1:0]  state;
  logic [15:0] count;
  logic        burst_edge;
  logic        fin_edge;

  sync_edge_det #(.SYNC_STAGES(2)) u_burst_edge (
    .CLK_65 (CLK_65),
    .RST    (RST),
    .D      (BURST),
    .EDGE   (burst_edge)
  );

  sync_edge_det #(.SYNC_STAGES(0)) u_fin_edge (
    .CLK_65 (CLK_65),
    .RST    (RST),
    .D      (SAMPLE_FIN),
    .EDGE   (fin_edge)
  );

  always_ff @(posedge CLK_65) begin
    if (RST) begin
      state        <= IDLE;
      count        <= '0;
      FIFO_WR      <= 1'b0;
      FIFO_DATA    <= '0;
      FRAME_ACTIVE <= 1'b0;
      OVERFLOW     <= 1'b0;
      FRAME_ID     <= '0;
    end else begin
      FIFO_WR <= 1'b0;
      if (!ON) begin
        // Abort: any in-flight write is dropped, the frame ID is kept.
        state        <= IDLE;
        FRAME_ACTIVE <= 1'b0;
        OVERFLOW     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (burst_edge && !OVERFLOW) begin
              state        <= HEADER;
              FRAME_ACTIVE <= 1'b1;
            end
          end
          HEADER: begin
            if (FIFO_FULL) begin
              OVERFLOW     <= 1'b1;
              state        <= IDLE;
              FRAME_ACTIVE <= 1'b0;
            end else begin
              FIFO_WR   <= 1'b1;
              FIFO_DATA <= {HEADER_TAG, FRAME_ID};
              count     <= '0;
              state     <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (fin_edge) begin
              if (FIFO_FULL) begin
                // The truncated frame still consumes its ID so the next header differs.
                OVERFLOW     <= 1'b1;
                FRAME_ID     <= FRAME_ID + 8'd1;
                state        <= IDLE;
                FRAME_ACTIVE <= 1'b0;
              end else begin
                FIFO_WR   <= 1'b1;
                FIFO_DATA <= sample_word(SAMPLE_DATA);
                count     <= count + 16'd1;
                if (count == LAST_INDEX) begin
                  FRAME_ID     <= FRAME_ID + 8'd1;
                  state        <= IDLE;
                  FRAME_ACTIVE <= 1'b0;
                end
              end
            end
          end
          default: begin
            state        <= IDLE;
            FRAME_ACTIVE <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_echo_frame_writer.sv
// Directed bench for echo_frame_writer with SAMPLES_PER_FRAME=4: vector table plus corner sequences.
module tb_echo_frame_writer;

  logic        CLK_65 = 1'b0;
  logic        RST;
  logic        ON;
  logic        BURST;
  logic        SAMPLE_FIN;
  logic [15:0] SAMPLE_DATA;
  logic        FIFO_FULL;
  logic        FIFO_WR;
  logic [15:0] FIFO_DATA;
  logic        FRAME_ACTIVE;
  logic        OVERFLOW;
  logic [7:0]  FRAME_ID;

  int n_checks = 0;
  int n_fail   = 0;

  echo_frame_writer #(.SAMPLES_PER_FRAME(4), .HEADER_TAG(8'hA5)) dut (
    .CLK_65       (CLK_65),
    .RST          (RST),
    .ON           (ON),
    .BURST        (BURST),
    .SAMPLE_FIN   (SAMPLE_FIN),
    .SAMPLE_DATA  (SAMPLE_DATA),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_WR      (FIFO_WR),
    .FIFO_DATA    (FIFO_DATA),
    .FRAME_ACTIVE (FRAME_ACTIVE),
    .OVERFLOW     (OVERFLOW),
    .FRAME_ID     (FRAME_ID)
  );

  always #5 CLK_65 = ~CLK_65;

  typedef struct {
    bit          start;
    logic [15:0] hdr;
    logic [15:0] data;
    bit          full;
    bit          exp_wr;
    logic [15:0] exp_word;
    bit          exp_active;
    bit          exp_ovf;
    logic [7:0]  exp_id;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK_65);
    #1;
  endtask

  logic prev_wr = 1'b0;
  always @(negedge CLK_65) begin
    if (FIFO_WR) check("no_back_to_back", 16'(prev_wr), 16'h0);
    prev_wr <= FIFO_WR;
  end

  // Raise BURST; the header write (if any) is visible after the 4th edge.
  task automatic start_frame(input bit exp_wr, input logic [15:0] exp_hdr, input bit exp_active);
    BURST = 1'b1;
    repeat (3) tick();
    check("hdr_not_early", 16'(FIFO_WR), 16'h0);
    tick();
    check("hdr_wr", 16'(FIFO_WR), 16'(exp_wr));
    if (exp_wr) check("hdr_word", FIFO_DATA, exp_hdr);
    check("hdr_active", 16'(FRAME_ACTIVE), 16'(exp_active));
    BURST = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_sample(input logic [15:0] d, input bit full,
                             output logic got_wr, output logic [15:0] got_data);
    SAMPLE_DATA = d;
    FIFO_FULL   = full;
    SAMPLE_FIN  = 1'b1;
    tick();
    got_wr   = FIFO_WR;
    got_data = FIFO_DATA;
    SAMPLE_FIN = 1'b0;
    FIFO_FULL  = 1'b0;
    tick();
    check("wr_single_cycle", 16'(FIFO_WR), 16'h0);
  endtask

  initial begin
    logic        wr;
    logic [15:0] wd;

    RST = 1'b1; ON = 1'b1; BURST = 1'b0; SAMPLE_FIN = 1'b0;
    SAMPLE_DATA = 16'h0; FIFO_FULL = 1'b0;

    //            start hdr      data     full wr word     act ovf id
    vecs[0] = '{1'b1, 16'hA500, 16'h0002, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 16'h0000, 16'h0004, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 16'h0000, 16'h0006, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 8'd0};
    vecs[3] = '{1'b0, 16'h0000, 16'h0008, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0, 8'd1};
    vecs[4] = '{1'b1, 16'hA501, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 8'd1};
    vecs[5] = '{1'b0, 16'h0000, 16'h8001, 1'b0, 1'b1, 16'h4000, 1'b1, 1'b0, 8'd1};
    vecs[6] = '{1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'd2};

    tick(); tick();
    check("rst_wr",     16'(FIFO_WR),      16'h0);
    check("rst_data",   FIFO_DATA,         16'h0);
    check("rst_active", 16'(FRAME_ACTIVE), 16'h0);
    check("rst_ovf",    16'(OVERFLOW),     16'h0);
    check("rst_id",     16'(FRAME_ID),     16'h0);
    RST = 1'b0;
    tick();

    // Cycle-exact burst latency from IDLE.
    BURST = 1'b1;
    tick(); tick();
    check("lat_c2_active", 16'(FRAME_ACTIVE), 16'h0);
    tick();
    check("lat_c3_active", 16'(FRAME_ACTIVE), 16'h1);
    check("lat_c3_wr",     16'(FIFO_WR),      16'h0);
    tick();
    check("lat_c4_wr",     16'(FIFO_WR),      16'h1);
    check("lat_c4_word",   FIFO_DATA,         16'hA500);
    BURST = 1'b0;
    repeat (3) tick();

    // Vector table: full frame, then a frame truncated by FIFO_FULL on its 3rd sample.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].start && i != 0) start_frame(1'b1, vecs[i].hdr, 1'b1);
      send_sample(vecs[i].data, vecs[i].full, wr, wd);
      check($sformatf("vec%0d_wr", i), 16'(wr), 16'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) check($sformatf("vec%0d_word", i), wd, vecs[i].exp_word);
      check($sformatf("vec%0d_active", i), 16'(FRAME_ACTIVE), 16'(vecs[i].exp_active));
      check($sformatf("vec%0d_ovf", i),    16'(OVERFLOW),     16'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_id", i),     16'(FRAME_ID),     16'(vecs[i].exp_id));
    end

    // OVERFLOW blocks new frames until ON drops.
    start_frame(1'b0, 16'h0, 1'b0);
    check("ovf_sticky", 16'(OVERFLOW), 16'h1);
    ON = 1'b0;
    tick();
    check("on_clr_ovf", 16'(OVERFLOW), 16'h0);
    check("on_keep_id", 16'(FRAME_ID), 16'd2);
    ON = 1'b1;
    tick();
    start_frame(1'b1, 16'hA502, 1'b1);

    // Re-trigger during CAPTURE is ignored, then RST mid-frame.
    send_sample(16'h0010, 1'b0, wr, wd);
    check("rt_s0", wd, 16'h0008);
    send_sample(16'h0020, 1'b0, wr, wd);
    check("rt_s1", wd, 16'h0010);
    start_frame(1'b0, 16'h0, 1'b1);
    send_sample(16'h0030, 1'b0, wr, wd);
    check("rt_s2_wr", 16'(wr), 16'h1);
    check("rt_s2", wd, 16'h0018);
    check("rt_id", 16'(FRAME_ID), 16'd2);
    RST = 1'b1;
    tick();
    check("mid_rst_wr",     16'(FIFO_WR),      16'h0);
    check("mid_rst_data",   FIFO_DATA,         16'h0);
    check("mid_rst_active", 16'(FRAME_ACTIVE), 16'h0);
    check("mid_rst_id",     16'(FRAME_ID),     16'h0);
    RST = 1'b0;
    tick();
    start_frame(1'b1, 16'hA500, 1'b1);

    // ON low coinciding with a FIN edge: write suppressed, frame aborted, ID kept.
    SAMPLE_DATA = 16'h00FF;
    SAMPLE_FIN  = 1'b1;
    ON          = 1'b0;
    tick();
    check("abort_wr",     16'(FIFO_WR),      16'h0);
    check("abort_active", 16'(FRAME_ACTIVE), 16'h0);
    check("abort_id",     16'(FRAME_ID),     16'h0);
    SAMPLE_FIN = 1'b0;
    ON         = 1'b1;
    tick();

    // FIFO full at header time: nothing written, ID unchanged.
    FIFO_FULL = 1'b1;
    start_frame(1'b0, 16'h0, 1'b0);
    check("fullhdr_ovf", 16'(OVERFLOW), 16'h1);
    check("fullhdr_id",  16'(FRAME_ID), 16'h0);
    FIFO_FULL = 1'b0;
    ON = 1'b0;
    tick();
    ON = 1'b1;
    tick();

    // 256 complete frames, then the ID has wrapped back to 0.
    for (int f = 0; f < 256; f++) begin
      start_frame(1'b1, {8'hA5, 8'(f)}, 1'b1);
      for (int s = 0; s < 4; s++) send_sample(16'(s * 2), 1'b0, wr, wd);
    end
    check("wrap_id", 16'(FRAME_ID), 16'h0);
    start_frame(1'b1, 16'hA500, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_frame_writer.md
Name: echo_frame_writer

Overview:
Sits between the ADC SPI master (FIN/DATA_MISO) and the 16-bit sample FIFO write port. It aligns capture to each ultrasonic burst and writes one framed record per burst into the FIFO: a header word followed by SAMPLES_PER_FRAME sample words. It replaces free-running FIFO writes and the manual overflow latch with frame-aware overflow handling, so the MBED side can resynchronise on headers.

Parameters:
SAMPLES_PER_FRAME, 512, sample words written per frame after the header (legal range 1..65535).
HEADER_TAG, 8'hA5, upper byte of the header word.

Ports:
CLK_65  in  1  system clock, 65 MHz
RST  in  1  reset, synchronous, active-high; clock CLK_65
ON  in  1  system enable (registered switch); low aborts the frame and clears OVERFLOW
BURST  in  1  high during burst (counter_burst<32) from the CLK_40 domain; asynchronous to CLK_65
SAMPLE_FIN  in  1  ADC SPI master FIN level; its rising edge marks a new sample
SAMPLE_DATA  in  16  ADC result, stable while SAMPLE_FIN is high
FIFO_FULL  in  1  FIFO full flag
FIFO_WR  out  1  single-cycle FIFO write request
FIFO_DATA  out  16  FIFO write data, valid while FIFO_WR=1
FRAME_ACTIVE  out  1  high in HEADER or CAPTURE
OVERFLOW  out  1  sticky: a frame was aborted because the FIFO was full
FRAME_ID  out  8  ID of the next frame to be started

Behaviour:
- Reset (RST=1): state IDLE; FIFO_WR=0, FIFO_DATA=0, FRAME_ACTIVE=0, OVERFLOW=0, FRAME_ID=0, sample count=0, synchroniser/edge registers=0.
- BURST goes through a 2-FF synchroniser, then a rising-edge detector. burst_edge is a 1-cycle pulse 3 CLK_65 edges after BURST rises.
- SAMPLE_FIN is same-domain and gets only an edge detector. fin_edge=SAMPLE_FIN & ~fin_prev.
- All outputs are registered. FIFO_WR and FIFO_DATA assert the cycle after the edge at which the triggering condition is sampled.
- Header word = {HEADER_TAG, FRAME_ID}. Bit 15 is 1 for the default tag.
- Sample word = {1'b0, SAMPLE_DATA[15:1]}. Bit 15 is always 0, so a header is unambiguous.
- FSM states: IDLE, HEADER, CAPTURE.
  - IDLE: if burst_edge & ON & ~OVERFLOW, go to HEADER; otherwise stay.
  - HEADER, one cycle:
    - FIFO_FULL=0: write the header, clear count, go to CAPTURE.
    - FIFO_FULL=1: set OVERFLOW, write nothing, go to IDLE.
    - A fin_edge in this cycle is discarded.
  - CAPTURE, on fin_edge:
    - FIFO_FULL=1: set OVERFLOW, increment FRAME_ID (the frame is consumed), go to IDLE. A truncated frame remains in the FIFO; the consumer detects it by the next header.
    - FIFO_FULL=0: write the sample word, count+1. When count reaches SAMPLES_PER_FRAME-1 on this write, increment FRAME_ID and go to IDLE.
- burst_edge while in HEADER or CAPTURE is ignored. No queueing and no restart.
- FRAME_ID wraps 255->0.
- The count is 16-bit and compared against SAMPLES_PER_FRAME-1.
- ON=0 in any state forces IDLE the next cycle, suppresses FIFO_WR in that same cycle, and clears OVERFLOW. FRAME_ID is kept.
- RST mid-frame returns everything to reset values. A pending write is dropped.
- OVERFLOW clears only on RST or ON=0. While it is set, no new frame starts.
- FIFO_WR never asserts on two consecutive cycles. It never asserts when FIFO_FULL was 1 at the deciding edge.
- FRAME_ACTIVE=1 exactly while the state is HEADER or CAPTURE (registered with the state).

Decomposition:
- Package echo_pkg: state encoding (IDLE=2'd0, HEADER=2'd1, CAPTURE=2'd2), default HEADER_TAG, SAMPLE_SHIFT=1.
- Sub-module sync_edge_det:
  - Parameter SYNC_STAGES: 2 for BURST, 0 for SAMPLE_FIN.
  - Ports: CLK_65, RST, D, EDGE.

Test Plan:
- Basic frame (SAMPLES_PER_FRAME=4): one BURST pulse, then 4 FIN edges with data 16'h0002, 0004, 0006, 0008 -> FIFO receives A500, 0001, 0002, 0003, 0004; FRAME_ID becomes 1; FRAME_ACTIVE drops after the 4th write.
- Latency and sync: BURST rises at cycle 0 with FIFO empty -> header FIFO_WR at cycle 4. FIN rises at cycle 10 -> FIFO_WR at cycle 11 only.
- FIFO full mid-frame: FIFO_FULL=1 before the 3rd sample -> 2 samples written, no 3rd write, OVERFLOW=1, state IDLE. A further BURST starts no frame. ON low for one cycle -> OVERFLOW=0, and the next burst writes header A501.
- FIFO full at header: FIFO_FULL=1 when BURST arrives -> no write, OVERFLOW=1, FRAME_ID unchanged (0).
- Re-trigger and abort: a second BURST during CAPTURE -> ignored, no new header. RST asserted after 2 samples -> all outputs 0 next cycle, and a later burst writes A500.
- Wrap: run 256 frames -> the 257th header is A500.
